// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x3 keypad matrix encoder.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } kp_state_e;

    localparam logic [3:0] KEY_STAR  = 4'd10;
    localparam logic [3:0] KEY_SHARP = 4'd11;

    // Indexed by row*3 + col; entry 0 is row 0 / column 0.
    localparam logic [11:0][3:0] KEY_MAP = {
        4'd11, 4'd0, 4'd10,
        4'd9,  4'd8, 4'd7,
        4'd6,  4'd5, 4'd4,
        4'd3,  4'd2, 4'd1
    };

    typedef struct packed {
        logic       single;
        logic [1:0] idx;
    } row_sample_t;

    function automatic row_sample_t decode_rows(input logic [3:0] rows_n);
        row_sample_t s;
        s.single = 1'b1;
        s.idx    = 2'd0;
        case (rows_n)
            4'b1110: s.idx = 2'd0;
            4'b1101: s.idx = 2'd1;
            4'b1011: s.idx = 2'd2;
            4'b0111: s.idx = 2'd3;
            default: s.single = 1'b0;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] idx;
        idx = ({2'b00, row} * 4'd3) + {2'b00, col};
        return KEY_MAP[idx];
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running divider; tick is high for the one cycle the count equals SCAN_DIV-1.
module keypad_tick_gen #(
    parameter int SCAN_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/keypad_matrix_encoder.sv
// 4x3 keypad scanner/debouncer producing one-hot digit plus active-low star/sharp.
// Optional stuck-key timeout enabled by defining KEYPAD_STUCK_TIMEOUT_EN.
module keypad_matrix_encoder
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV    = 1000,
    parameter int DEB_CNT     = 4,
    parameter int STUCK_TICKS = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [2:0] col_n,
    output logic [9:0] number,
    output logic       star,
    output logic       sharp,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       stuck
);

    if (SCAN_DIV < 4 || DEB_CNT < 1 || STUCK_TICKS < 1) begin : g_param_check
        $error("keypad_matrix_encoder: invalid parameter values");
    end

    localparam int DW = $clog2(DEB_CNT + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CNT - 1);

    logic            tick;
    logic [3:0]      row_meta_reg;
    logic [3:0]      row_sync_reg;
    kp_state_e       state_reg;
    logic [1:0]      col_reg;
    logic [1:0]      row_lat_reg;
    logic [DW-1:0]   deb_reg;
    logic [DW-1:0]   rel_reg;
    logic [9:0]      number_reg;
    logic            star_reg;
    logic            sharp_reg;
    logic            key_valid_reg;
    logic [3:0]      key_code_reg;

    row_sample_t     samp;
    logic            lat_row_high;
    logic [1:0]      col_adv;
    logic [3:0]      acc_code;
    logic            accept_now;
    logic            release_now;

    keypad_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta_reg <= '1;
            row_sync_reg <= '1;
        end else begin
            row_meta_reg <= row_n;
            row_sync_reg <= row_meta_reg;
        end
    end

    assign samp         = decode_rows(row_sync_reg);
    assign lat_row_high = row_sync_reg[row_lat_reg];
    assign col_adv      = (col_reg == 2'd2) ? 2'd0 : col_reg + 2'd1;
    // When accepting, the sampled row always equals the latched row.
    assign acc_code     = key_lookup(samp.idx, col_reg);

    always_comb begin
        accept_now  = 1'b0;
        release_now = 1'b0;
        if (tick) begin
            case (state_reg)
                SCAN:     accept_now  = samp.single && (DEB_CNT == 1);
                DEBOUNCE: accept_now  = samp.single && (samp.idx == row_lat_reg) && (deb_reg == DEB_LAST);
                PRESSED:  release_now = lat_row_high && (DEB_CNT == 1);
                RELEASE:  release_now = lat_row_high && (rel_reg == DEB_LAST);
                default:  ;
            endcase
        end
    end

`ifdef KEYPAD_STUCK_TIMEOUT_EN
    localparam int SW = $clog2(STUCK_TICKS + 1);
    localparam logic [SW-1:0] STUCK_LAST = SW'(STUCK_TICKS - 1);

    logic [SW-1:0] stuck_cnt_reg;
    logic          stuck_reg;
    logic          stuck_hit;

    assign stuck_hit = tick && (state_reg == PRESSED) && !lat_row_high &&
                       !stuck_reg && (stuck_cnt_reg == STUCK_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stuck_cnt_reg <= '0;
            stuck_reg     <= 1'b0;
        end else begin
            if (accept_now) begin
                stuck_cnt_reg <= '0;
            end else if (tick && state_reg == PRESSED && !lat_row_high && !stuck_reg &&
                         stuck_cnt_reg != STUCK_LAST) begin
                stuck_cnt_reg <= stuck_cnt_reg + SW'(1);
            end
            if (release_now) begin
                stuck_reg <= 1'b0;
            end else if (stuck_hit) begin
                stuck_reg <= 1'b1;
            end
        end
    end

    assign stuck = stuck_reg;
`else
    assign stuck = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= SCAN;
            col_reg       <= 2'd0;
            row_lat_reg   <= 2'd0;
            deb_reg       <= '0;
            rel_reg       <= '0;
            number_reg    <= '0;
            star_reg      <= 1'b1;
            sharp_reg     <= 1'b1;
            key_valid_reg <= 1'b0;
            key_code_reg  <= '0;
        end else begin
            key_valid_reg <= 1'b0;
            if (tick) begin
                case (state_reg)
                    SCAN: begin
                        if (samp.single) begin
                            row_lat_reg <= samp.idx;
                            deb_reg     <= DW'(1);
                            state_reg   <= DEBOUNCE;
                        end else begin
                            col_reg <= col_adv;
                        end
                    end
                    DEBOUNCE: begin
                        if (samp.single && samp.idx == row_lat_reg) begin
                            deb_reg <= deb_reg + DW'(1);
                        end else begin
                            deb_reg   <= '0;
                            state_reg <= SCAN;
                            col_reg   <= col_adv;
                        end
                    end
                    PRESSED: begin
                        // Only the latched row matters; chords added later are ignored.
                        if (lat_row_high) begin
                            rel_reg   <= DW'(1);
                            state_reg <= RELEASE;
                        end
                    end
                    RELEASE: begin
                        if (lat_row_high) begin
                            rel_reg <= rel_reg + DW'(1);
                        end else begin
                            rel_reg   <= '0;
                            state_reg <= PRESSED;
                        end
                    end
                    default: state_reg <= SCAN;
                endcase
            end

            if (accept_now) begin
                state_reg     <= PRESSED;
                deb_reg       <= '0;
                key_valid_reg <= 1'b1;
                key_code_reg  <= acc_code;
                number_reg    <= (acc_code < 4'd10) ? (10'b1 << acc_code) : 10'b0;
                star_reg      <= (acc_code != KEY_STAR);
                sharp_reg     <= (acc_code != KEY_SHARP);
            end

`ifdef KEYPAD_STUCK_TIMEOUT_EN
            if (stuck_hit) begin
                number_reg <= '0;
                star_reg   <= 1'b1;
                sharp_reg  <= 1'b1;
            end
`endif

            if (release_now) begin
                state_reg  <= SCAN;
                col_reg    <= col_adv;
                rel_reg    <= '0;
                number_reg <= '0;
                star_reg   <= 1'b1;
                sharp_reg  <= 1'b1;
            end
        end
    end

    assign col_n     = ~(3'b001 << col_reg);
    assign number    = number_reg;
    assign star      = star_reg;
    assign sharp     = sharp_reg;
    assign key_valid = key_valid_reg;
    assign key_code  = key_code_reg;

endmodule
